mem_req_arbiter: RTL and testbench

//  Shares the byte-serial memory controller between instruction fetch and the load/store buffer.

---
 rtl/mem_req_arbiter_if.sv | 33 +++
 rtl/mem_req_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Request, completion and memory-controller signals shared by the arbiter and its clients.
// The arbiter connects through the master modport; requesters and the controller use slave.
interface mem_req_arbiter_if;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_done;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic        mc_if_en;
    logic        mc_lsb_en;
    logic [31:0] mc_addr;
    logic        mc_wr;
    logic [2:0]  mc_len;
    logic [31:0] mc_wdata;
    logic        mc_if_done;
    logic        mc_lsb_done;

    modport master (
        input  if_req, if_pc, lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
               mc_if_done, mc_lsb_done,
        output if_done, lsb_done, mc_if_en, mc_lsb_en, mc_addr, mc_wr, mc_len, mc_wdata
    );

    modport slave (
        output if_req, if_pc, lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
               mc_if_done, mc_lsb_done,
        input  if_done, lsb_done, mc_if_en, mc_lsb_en, mc_addr, mc_wr, mc_len, mc_wdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch and the load/store
// buffer, with rollback handling and fetch aging; every output is a flop.
module mem_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WID      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              rollback,
    mem_req_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        GNT_IF,
        GNT_LD,
        GNT_ST,
        COOL
    } state_e;

    localparam logic [CNT_WID-1:0] LIMIT = CNT_WID'(STARVE_LIMIT);

    state_e             state_q, state_d;
    logic [CNT_WID-1:0] starve_cnt_q, starve_cnt_d;
    logic               cool_cnt_q, cool_cnt_d;
    logic               kill_q, kill_d;

    logic               if_done_q, if_done_d;
    logic               lsb_done_q, lsb_done_d;
    logic               mc_if_en_q, mc_if_en_d;
    logic               mc_lsb_en_q, mc_lsb_en_d;
    logic [31:0]        mc_addr_q, mc_addr_d;
    logic               mc_wr_q, mc_wr_d;
    logic [2:0]         mc_len_q, mc_len_d;
    logic [31:0]        mc_wdata_q, mc_wdata_d;

    logic               arb_open;
    logic               grant_lsb;
    logic               grant_if;
    logic               if_fin;
    logic               ld_abort;
    logic               lsb_fin;

    // Fetch only wins a contested cycle once the LSB has taken STARVE_LIMIT grants in a row.
    always_comb begin
        arb_open  = (state_q == IDLE) && !rollback;
        grant_lsb = arb_open && bus.lsb_req && (!bus.if_req || (starve_cnt_q < LIMIT));
        grant_if  = arb_open && !grant_lsb && bus.if_req;
        if_fin    = (state_q == GNT_IF) && bus.mc_if_done;
        ld_abort  = (state_q == GNT_LD) && rollback;
        lsb_fin   = bus.mc_lsb_done &&
                    ((state_q == GNT_ST) || ((state_q == GNT_LD) && !rollback));
    end

    // Next-state process: FSM state plus the starvation, cool-down and kill bookkeeping.
    always_comb begin
        // NOTE: every signal starts from its held value so no path leaves it unassigned,
        // which keeps this block purely combinational (no latches).
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cool_cnt_d   = cool_cnt_q;
        kill_d       = kill_q;

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (grant_lsb) begin
                        state_d = bus.lsb_wr ? GNT_ST : GNT_LD;
                        if (bus.if_req) begin
                            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT
                                                                   : starve_cnt_q + CNT_WID'(1);
                        end else begin
                            starve_cnt_d = '0;
                        end
                    end else if (grant_if) begin
                        state_d      = GNT_IF;
                        starve_cnt_d = '0;
                    end
                end
                GNT_IF: begin
                    if (bus.mc_if_done) begin
                        state_d    = COOL;
                        cool_cnt_d = 1'b1;
                        kill_d     = 1'b0;
                    end else if (rollback) begin
                        kill_d = 1'b1;
                    end
                end
                GNT_LD: begin
                    if (rollback) begin
                        state_d = IDLE;
                    end else if (bus.mc_lsb_done) begin
                        state_d    = COOL;
                        cool_cnt_d = 1'b1;
                    end
                end
                GNT_ST: begin
                    if (bus.mc_lsb_done) begin
                        state_d    = COOL;
                        cool_cnt_d = 1'b1;
                    end
                end
                COOL: begin
                    if (cool_cnt_q) begin
                        cool_cnt_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output process: next values of the registered controller and requester outputs.
    always_comb begin
        if_done_d   = if_done_q;
        lsb_done_d  = lsb_done_q;
        mc_if_en_d  = mc_if_en_q;
        mc_lsb_en_d = mc_lsb_en_q;
        mc_addr_d   = mc_addr_q;
        mc_wr_d     = mc_wr_q;
        mc_len_d    = mc_len_q;
        mc_wdata_d  = mc_wdata_q;

        if (rdy) begin
            // A fetch flushed before its line returns is completed silently.
            if_done_d  = if_fin && !kill_q && !rollback;
            lsb_done_d = lsb_fin;

            if (grant_lsb) begin
                mc_lsb_en_d = 1'b1;
                mc_addr_d   = bus.lsb_addr;
                mc_wr_d     = bus.lsb_wr;
                mc_len_d    = bus.lsb_len;
                mc_wdata_d  = bus.lsb_wdata;
            end else if (grant_if) begin
                mc_if_en_d  = 1'b1;
                mc_addr_d   = bus.if_pc;
                mc_wr_d     = 1'b0;
                mc_len_d    = '0;
                mc_wdata_d  = '0;
            end

            if (if_fin) begin
                mc_if_en_d = 1'b0;
            end
            if (lsb_fin || ld_abort) begin
                mc_lsb_en_d = 1'b0;
            end
        end
    end

    // State register: rdy gating lives in the _d logic, so every flop simply loads its _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            cool_cnt_q   <= 1'b0;
            kill_q       <= 1'b0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            mc_if_en_q   <= 1'b0;
            mc_lsb_en_q  <= 1'b0;
            mc_addr_q    <= '0;
            mc_wr_q      <= 1'b0;
            mc_len_q     <= '0;
            mc_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values,
            // independent of statement order.
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cool_cnt_q   <= cool_cnt_d;
            kill_q       <= kill_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            mc_if_en_q   <= mc_if_en_d;
            mc_lsb_en_q  <= mc_lsb_en_d;
            mc_addr_q    <= mc_addr_d;
            mc_wr_q      <= mc_wr_d;
            mc_len_q     <= mc_len_d;
            mc_wdata_q   <= mc_wdata_d;
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.mc_if_en  = mc_if_en_q;
    assign bus.mc_lsb_en = mc_lsb_en_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_wr     = mc_wr_q;
    assign bus.mc_len    = mc_len_q;
    assign bus.mc_wdata  = mc_wdata_q;

`ifndef SYNTHESIS
    a_one_enable: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.mc_if_en && bus.mc_lsb_en));
    a_one_done: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.if_done && bus.lsb_done));
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter; expected grants and pulses come from a
// transaction-level model of the arbitration and completion rules.
module tb_mem_req_arbiter;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {K_NONE, K_IF, K_LD, K_ST} kind_e;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic rdy      = 1'b1;
    logic rollback = 1'b0;

    mem_req_arbiter_if bus ();

    mem_req_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_WID     (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .rollback(rollback),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: what each requester is asking for, and how many LSB grants in a row
    // have been taken while fetch was waiting.
    bit          if_pend  = 1'b0;
    bit          lsb_pend = 1'b0;
    logic [31:0] pc_m     = '0;
    logic [31:0] addr_m   = '0;
    logic [31:0] wdata_m  = '0;
    logic        wr_m     = 1'b0;
    logic [2:0]  len_m    = '0;
    int          streak   = 0;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check_bit({tag, "_if_done"}, bus.if_done, 1'b0);
        check_bit({tag, "_lsb_done"}, bus.lsb_done, 1'b0);
        check_bit({tag, "_mc_if_en"}, bus.mc_if_en, 1'b0);
        check_bit({tag, "_mc_lsb_en"}, bus.mc_lsb_en, 1'b0);
        check_word({tag, "_mc_addr"}, bus.mc_addr, 32'h0);
        check_bit({tag, "_mc_wr"}, bus.mc_wr, 1'b0);
        check_word({tag, "_mc_len"}, 32'(bus.mc_len), 32'h0);
        check_word({tag, "_mc_wdata"}, bus.mc_wdata, 32'h0);
    endtask

    task automatic raise_if(input logic [31:0] pc);
        if_pend    = 1'b1;
        pc_m       = pc;
        bus.if_pc  = pc;
        bus.if_req = 1'b1;
    endtask

    task automatic raise_lsb(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                             input logic [31:0] wdata);
        lsb_pend      = 1'b1;
        wr_m          = wr;
        addr_m        = addr;
        len_m         = len;
        wdata_m       = wdata;
        bus.lsb_wr    = wr;
        bus.lsb_addr  = addr;
        bus.lsb_len   = len;
        bus.lsb_wdata = wdata;
        bus.lsb_req   = 1'b1;
    endtask

    // One arbitration: predict the winner, play the controller for lat cycles (optional
    // rollback on cycle rb_at), then check the completion pulse and the two cool cycles.
    task automatic run_txn(input int lat, input int rb_at, output kind_e got);
        kind_e       exp_k;
        logic [31:0] e_addr;
        logic        e_wr;
        logic [2:0]  e_len;
        int          rb;
        bit          killed;
        bit          rb_now;
        bit          abort_now;
        killed = 1'b0;
        if (lsb_pend && (!if_pend || streak < STARVE_LIMIT)) begin
            exp_k  = wr_m ? K_ST : K_LD;
            streak = if_pend ? streak + 1 : 0;
            e_addr = addr_m;
            e_wr   = wr_m;
            e_len  = len_m;
        end else begin
            exp_k  = K_IF;
            streak = 0;
            e_addr = pc_m;
            e_wr   = 1'b0;
            e_len  = 3'd0;
        end
        rb = (exp_k == K_IF && rb_at >= lat) ? 0 : rb_at;

        @(negedge clk);
        if (bus.mc_if_en)       got = K_IF;
        else if (bus.mc_lsb_en) got = bus.mc_wr ? K_ST : K_LD;
        else                    got = K_NONE;
        check_bit("grant_if_en", bus.mc_if_en, exp_k == K_IF);
        check_bit("grant_lsb_en", bus.mc_lsb_en, exp_k != K_IF);
        check_word("grant_addr", bus.mc_addr, e_addr);
        check_bit("grant_wr", bus.mc_wr, e_wr);
        check_word("grant_len", 32'(bus.mc_len), 32'(e_len));
        if (exp_k != K_IF) check_word("grant_wdata", bus.mc_wdata, wdata_m);

        for (int c = 1; c <= lat; c++) begin
            rb_now    = (rb == c);
            abort_now = rb_now && (exp_k == K_LD);
            rollback  = rb_now;
            if (exp_k == K_IF) begin
                bus.mc_if_done  = (c == lat);
                bus.mc_lsb_done = (c != lat) && ($urandom_range(0, 3) == 0);
                if (rb_now) begin
                    killed     = 1'b1;
                    if_pend    = 1'b0;
                    bus.if_req = 1'b0;
                end
            end else begin
                bus.mc_lsb_done = (c == lat);
                bus.mc_if_done  = (c != lat) && ($urandom_range(0, 3) == 0);
                if (abort_now) begin
                    lsb_pend    = 1'b0;
                    bus.lsb_req = 1'b0;
                end
            end
            @(negedge clk);
            rollback        = 1'b0;
            bus.mc_if_done  = 1'b0;
            bus.mc_lsb_done = 1'b0;
            if (abort_now) begin
                check_bit("abort_en", bus.mc_lsb_en, 1'b0);
                check_bit("abort_done", bus.lsb_done, 1'b0);
                break;
            end else if (c < lat) begin
                check_bit("wait_en", (exp_k == K_IF) ? bus.mc_if_en : bus.mc_lsb_en, 1'b1);
                check_bit("wait_no_done", bus.if_done | bus.lsb_done, 1'b0);
            end else begin
                check_bit("fin_en", bus.mc_if_en | bus.mc_lsb_en, 1'b0);
                check_bit("fin_if_done", bus.if_done, (exp_k == K_IF) && !killed);
                check_bit("fin_lsb_done", bus.lsb_done, exp_k != K_IF);
                if (exp_k == K_IF) begin
                    if_pend    = 1'b0;
                    bus.if_req = 1'b0;
                end else begin
                    lsb_pend    = 1'b0;
                    bus.lsb_req = 1'b0;
                end
                @(negedge clk);
                check_bit("pulse_end", bus.if_done | bus.lsb_done, 1'b0);
                check_bit("cool_a_en", bus.mc_if_en | bus.mc_lsb_en, 1'b0);
                @(negedge clk);
                check_bit("cool_b_en", bus.mc_if_en | bus.mc_lsb_en, 1'b0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within 1000000 time units");
        $fatal(1);
    end

    initial begin
        kind_e k;
        kind_e exp_order[6];
        int    lat;
        int    rb;
        exp_order = '{K_LD, K_LD, K_LD, K_LD, K_IF, K_LD};

        bus.if_req      = 1'b0;
        bus.if_pc       = '0;
        bus.lsb_req     = 1'b0;
        bus.lsb_wr      = 1'b0;
        bus.lsb_addr    = '0;
        bus.lsb_len     = '0;
        bus.lsb_wdata   = '0;
        bus.mc_if_done  = 1'b0;
        bus.mc_lsb_done = 1'b0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Lone fetch with a long controller latency.
        raise_if(32'h0000_1000);
        run_txn(66, 0, k);
        check_word("t1_kind", 32'(k), 32'(K_IF));

        // Fetch held against back-to-back loads.
        raise_if(32'h0000_1100);
        for (int i = 0; i < 6; i++) begin
            if (!lsb_pend) raise_lsb(1'b0, 32'h2000_0000 + 32'(i * 4), 3'd2, 32'h0);
            run_txn(3, 0, k);
            check_word("t2_order", 32'(k), 32'(exp_order[i]));
        end

        // Load aborted by rollback on its second cycle; fetch granted straight after.
        raise_lsb(1'b0, 32'h0000_0400, 3'd2, 32'h0);
        raise_if(32'h0000_1200);
        run_txn(5, 2, k);
        check_word("t3_kind", 32'(k), 32'(K_LD));
        run_txn(2, 0, k);
        check_word("t3_next", 32'(k), 32'(K_IF));

        // Killed fetch, then a normal one.
        raise_if(32'h0000_1300);
        run_txn(6, 3, k);
        raise_if(32'h0000_2000);
        run_txn(4, 0, k);
        check_word("t4_kind", 32'(k), 32'(K_IF));

        // Store survives rollback.
        raise_lsb(1'b1, 32'h0003_0000, 3'd2, 32'hDEAD_BEEF);
        run_txn(4, 2, k);
        check_word("t5_kind", 32'(k), 32'(K_ST));

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) raise_if($urandom & 32'hFFFF_FFFC);
            if (!lsb_pend && $urandom_range(0, 2) != 0)
                raise_lsb(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom);
            if (!if_pend && !lsb_pend) raise_if($urandom & 32'hFFFF_FFFC);
            lat = $urandom_range(1, 8);
            rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            run_txn(lat, rb, k);
        end

        // Asynchronous reset in the middle of a fetch grant.
        raise_if(32'h0000_4000);
        @(negedge clk);
        check_bit("t6_grant", bus.mc_if_en, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async_rst");
        bus.if_req  = 1'b0;
        bus.lsb_req = 1'b0;
        if_pend     = 1'b0;
        lsb_pend    = 1'b0;
        streak      = 0;
        @(negedge clk);
        check_zero("t6_rst_hold");
        rst_n = 1'b1;

        // rdy low freezes a grant (controller done ignored), then a done pulse.
        raise_if(32'h0000_5000);
        @(negedge clk);
        check_bit("t6_grant2", bus.mc_if_en, 1'b1);
        rdy            = 1'b0;
        bus.mc_if_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("frz_en", bus.mc_if_en, 1'b1);
            check_bit("frz_done", bus.if_done, 1'b0);
            check_word("frz_addr", bus.mc_addr, 32'h0000_5000);
        end
        rdy = 1'b1;
        @(negedge clk);
        bus.mc_if_done = 1'b0;
        bus.if_req     = 1'b0;
        if_pend        = 1'b0;
        check_bit("t6_fin_en", bus.mc_if_en, 1'b0);
        check_bit("t6_if_done", bus.if_done, 1'b1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("frz_pulse", bus.if_done, 1'b1);
        end
        rdy = 1'b1;
        @(negedge clk);
        check_bit("t6_pulse_end", bus.if_done, 1'b0);
        @(negedge clk);
        raise_lsb(1'b0, 32'h0000_0600, 3'd1, 32'h0);
        run_txn(2, 0, k);
        check_word("t6_resume", 32'(k), 32'(K_LD));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
